// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core's memory-side logic.
package idli_pkg;

  typedef enum logic {
    SQI_IO_MODE_IN,
    SQI_IO_MODE_OUT
  } sqi_io_mode_t;

  typedef enum logic [2:0] {
    INIT, IDLE, CMD, ADDR, DUMMY, DATA, DESEL
  } sqi_ctrl_state_t;

  typedef enum logic {
    SQI_OWNER_IFU,
    SQI_OWNER_LSU
  } sqi_owner_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;
  localparam logic [7:0] SQI_CMD_EQIO  = 8'h38;

  // Nibble idx of a word, MSB nibble first.
  function automatic logic [3:0] sqi_nib(input logic [15:0] w, input logic [1:0] idx);
    logic [15:0] s;
    s = w << {idx, 2'b00};
    return s[15:12];
  endfunction

endpackage

// File: rtl/idli_sqi_arb_m.sv
// Two-way round-robin arbiter: bit 0 = IFU, bit 1 = LSU.
module idli_sqi_arb_m
  import idli_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant,
  output sqi_owner_t o_owner
);

  sqi_owner_t r_last;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) o_grant = (r_last == SQI_OWNER_LSU) ? 2'b01 : 2'b10;
    o_owner = o_grant[1] ? SQI_OWNER_LSU : SQI_OWNER_IFU;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    r_last <= SQI_OWNER_LSU;
    else if (i_advance && |i_req)    r_last <= o_owner;
  end

endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// SQI serial SRAM sequencer: EQIO init, then one 16-bit read/write per grant
// between the fetch and load/store requesters.
module idli_sqi_ctrl_m
  import idli_pkg::*;
#(
  parameter bit INIT_EN = 1'b1
) (
  input  logic         i_sqi_gck,
  input  logic         i_sqi_rst_n,
  input  logic         i_sqi_ifu_req,
  input  logic [15:0]  i_sqi_ifu_addr,
  output logic         o_sqi_ifu_ack,
  output logic         o_sqi_ifu_done,
  input  logic         i_sqi_lsu_req,
  input  logic         i_sqi_lsu_wr,
  input  logic [15:0]  i_sqi_lsu_addr,
  input  logic [15:0]  i_sqi_lsu_wdata,
  output logic         o_sqi_lsu_ack,
  output logic         o_sqi_lsu_done,
  output logic [15:0]  o_sqi_rdata,
  output logic         o_sqi_sck,
  output logic         o_sqi_cs,
  output sqi_io_mode_t o_sqi_io_mode,
  input  logic [3:0]   i_sqi_sio,
  output logic [3:0]   o_sqi_sio
);

  sqi_ctrl_state_t r_state, w_nxt;
  logic [2:0]  r_beat, w_last_beat;
  logic        r_ph, r_run, r_from_init, r_wr;
  sqi_owner_t  r_owner, w_owner;
  logic [15:0] r_addr, r_wdata, r_rdata;
  logic [11:0] r_shift;
  logic [1:0]  w_grant;
  logic        w_adv, w_state_end, w_done;
  logic [7:0]  w_cmd;

  // r_run holds everything quiet for the first cycle after reset release,
  // so reset alone never exposes an active INIT or a grant.
  assign w_adv = r_run && (r_state == IDLE) && (i_sqi_ifu_req || i_sqi_lsu_req);

  idli_sqi_arb_m u_arb (
    .i_clk     (i_sqi_gck),
    .i_rst_n   (i_sqi_rst_n),
    .i_req     ({i_sqi_lsu_req, i_sqi_ifu_req}),
    .i_advance (w_adv),
    .o_grant   (w_grant),
    .o_owner   (w_owner)
  );

  always_comb begin
    w_last_beat = 3'd0;
    case (r_state)
      INIT:        w_last_beat = 3'd7;
      CMD, DUMMY:  w_last_beat = 3'd1;
      ADDR, DATA:  w_last_beat = 3'd3;
      default:     w_last_beat = 3'd0;
    endcase
  end

  assign w_state_end = r_ph && (r_beat == w_last_beat);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_adv) w_nxt = CMD;
      INIT:    if (w_state_end) w_nxt = DESEL;
      CMD:     if (w_state_end) w_nxt = ADDR;
      ADDR:    if (w_state_end) w_nxt = r_wr ? DATA : DUMMY;
      DUMMY:   if (w_state_end) w_nxt = DATA;
      DATA:    if (w_state_end) w_nxt = DESEL;
      DESEL:   if (w_state_end) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      r_state     <= INIT_EN ? INIT : IDLE;
      r_beat      <= 3'd0;
      r_ph        <= 1'b0;
      r_run       <= 1'b0;
      r_from_init <= INIT_EN;
      r_owner     <= SQI_OWNER_LSU;
      r_wr        <= 1'b0;
      r_addr      <= 16'h0;
      r_wdata     <= 16'h0;
      r_shift     <= 12'h0;
      r_rdata     <= 16'h0;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else begin
      r_state <= w_nxt;
      if (r_state != IDLE) begin
        r_ph <= ~r_ph;
        if (w_state_end) r_beat <= 3'd0;
        else if (r_ph)   r_beat <= r_beat + 3'd1;
      end
      if (w_adv) begin
        r_from_init <= 1'b0;
        r_owner     <= w_owner;
        r_wr        <= w_grant[1] && i_sqi_lsu_wr;
        r_addr      <= w_grant[1] ? i_sqi_lsu_addr : i_sqi_ifu_addr;
        r_wdata     <= i_sqi_lsu_wdata;
      end
      // Read nibbles are taken on the gck edge that closes the SCK-high phase.
      if (r_state == DATA && !r_wr && r_ph) begin
        r_shift <= {r_shift[7:0], i_sqi_sio};
        if (r_beat == 3'd3) r_rdata <= {r_shift, i_sqi_sio};
      end
    end
  end

  assign w_cmd = r_wr ? SQI_CMD_WRITE : SQI_CMD_READ;

  always_comb begin
    o_sqi_cs      = 1'b1;
    o_sqi_sck     = 1'b0;
    o_sqi_io_mode = SQI_IO_MODE_IN;
    o_sqi_sio     = 4'h0;
    if (r_run) begin
      case (r_state)
        INIT: begin
          o_sqi_cs = 1'b0; o_sqi_sck = r_ph; o_sqi_io_mode = SQI_IO_MODE_OUT;
          o_sqi_sio = {3'b000, SQI_CMD_EQIO[3'd7 - r_beat]};
        end
        CMD: begin
          o_sqi_cs = 1'b0; o_sqi_sck = r_ph; o_sqi_io_mode = SQI_IO_MODE_OUT;
          o_sqi_sio = r_beat[0] ? w_cmd[3:0] : w_cmd[7:4];
        end
        ADDR: begin
          o_sqi_cs = 1'b0; o_sqi_sck = r_ph; o_sqi_io_mode = SQI_IO_MODE_OUT;
          o_sqi_sio = sqi_nib(r_addr, r_beat[1:0]);
        end
        DUMMY: begin
          o_sqi_cs = 1'b0; o_sqi_sck = r_ph;
        end
        DATA: begin
          o_sqi_cs = 1'b0; o_sqi_sck = r_ph;
          if (r_wr) begin
            o_sqi_io_mode = SQI_IO_MODE_OUT;
            o_sqi_sio     = sqi_nib(r_wdata, r_beat[1:0]);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_done         = r_run && (r_state == DESEL) && !r_ph && !r_from_init;
  assign o_sqi_ifu_done = w_done && (r_owner == SQI_OWNER_IFU);
  assign o_sqi_lsu_done = w_done && (r_owner == SQI_OWNER_LSU);
  assign o_sqi_ifu_ack  = w_adv && w_grant[0];
  assign o_sqi_lsu_ack  = w_adv && w_grant[1];
  assign o_sqi_rdata    = r_rdata;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed bench for idli_sqi_ctrl_m with a small behavioural SQI SRAM model.
module tb_idli_sqi_ctrl_m;
  import idli_pkg::*;

  logic gck = 1'b0;
  logic rst_n = 1'b1;
  always #5 gck = ~gck;
  int cyc = 0;
  always @(posedge gck) cyc++;

  logic        ifu_req = 0, lsu_req = 0, lsu_wr = 0;
  logic [15:0] ifu_addr = 0, lsu_addr = 0, lsu_wdata = 0;
  logic [3:0]  sio_in0 = 0, sio_in1 = 0;

  logic ifu_ack0, ifu_done0, lsu_ack0, lsu_done0, sck0, cs0;
  logic ifu_ack1, ifu_done1, lsu_ack1, lsu_done1, sck1, cs1;
  logic [15:0] rdata0, rdata1;
  logic [3:0]  sio_out0, sio_out1;
  sqi_io_mode_t mode0, mode1;

  idli_sqi_ctrl_m #(.INIT_EN(1'b1)) dut0 (
    .i_sqi_gck(gck), .i_sqi_rst_n(rst_n),
    .i_sqi_ifu_req(ifu_req), .i_sqi_ifu_addr(ifu_addr),
    .o_sqi_ifu_ack(ifu_ack0), .o_sqi_ifu_done(ifu_done0),
    .i_sqi_lsu_req(lsu_req), .i_sqi_lsu_wr(lsu_wr), .i_sqi_lsu_addr(lsu_addr),
    .i_sqi_lsu_wdata(lsu_wdata), .o_sqi_lsu_ack(lsu_ack0), .o_sqi_lsu_done(lsu_done0),
    .o_sqi_rdata(rdata0), .o_sqi_sck(sck0), .o_sqi_cs(cs0), .o_sqi_io_mode(mode0),
    .i_sqi_sio(sio_in0), .o_sqi_sio(sio_out0));

  idli_sqi_ctrl_m #(.INIT_EN(1'b0)) dut1 (
    .i_sqi_gck(gck), .i_sqi_rst_n(rst_n),
    .i_sqi_ifu_req(ifu_req), .i_sqi_ifu_addr(ifu_addr),
    .o_sqi_ifu_ack(ifu_ack1), .o_sqi_ifu_done(ifu_done1),
    .i_sqi_lsu_req(lsu_req), .i_sqi_lsu_wr(lsu_wr), .i_sqi_lsu_addr(lsu_addr),
    .i_sqi_lsu_wdata(lsu_wdata), .o_sqi_lsu_ack(lsu_ack1), .o_sqi_lsu_done(lsu_done1),
    .o_sqi_rdata(rdata1), .o_sqi_sck(sck1), .o_sqi_cs(cs1), .o_sqi_io_mode(mode1),
    .i_sqi_sio(sio_in1), .o_sqi_sio(sio_out1));

  // SRAM model for dut0: single-bit until EQIO seen, then quad command/addr/data.
  logic        qmode = 0, cs_p = 1, preloaded = 0, init_hi = 0;
  logic [7:0]  bits = 0, last_init = 0;
  int          nbits = 0;
  logic [3:0]  nibq[$];
  logic [15:0] maddr = 0, rword = 0;
  logic [7:0]  mem [logic [15:0]];

  always @(posedge sck0 or negedge cs0 or posedge cs0 or negedge rst_n) begin
    if (!rst_n) begin
      qmode = 0; nbits = 0; last_init = 0; init_hi = 0;
      if (!preloaded) begin
        mem[16'h1234] = 8'hBE; mem[16'h1235] = 8'hEF; preloaded = 1;
      end
    end else if (cs0 && !cs_p) begin
      if (!qmode && nbits == 8) begin
        last_init = bits;
        if (bits == SQI_CMD_EQIO) qmode = 1;
      end else if (qmode && nibq.size() == 10 && nibq[1] == 4'h2) begin
        mem[maddr] = {nibq[6], nibq[7]};
        mem[maddr + 16'd1] = {nibq[8], nibq[9]};
      end
    end else if (!cs0 && cs_p) begin
      nibq.delete(); nbits = 0;
    end else if (!cs0 && sck0) begin
      if (!qmode) begin
        bits = {bits[6:0], sio_out0[0]}; nbits++;
        if (sio_out0[3:1] != 3'b000) init_hi = 1;
      end else begin
        nibq.push_back(sio_out0);
        if (nibq.size() == 6) begin
          maddr = {nibq[2], nibq[3], nibq[4], nibq[5]};
          rword = {mem[maddr], mem[maddr + 16'd1]};
        end
        if (nibq.size() >= 9 && nibq.size() <= 12 && nibq[1] == 4'h3) begin
          sio_in0 = rword[15:12]; rword = rword << 4;
        end
      end
    end
    cs_p = cs0;
  end

  logic [3:0] nibq1[$];
  always @(posedge sck1 or negedge cs1) begin
    if (!cs1 && sck1) nibq1.push_back(sio_out1);
    else if (!cs1)    nibq1.delete();
  end

  int n_run = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(); @(posedge gck); #2; endtask

  task automatic wait_ack(input int lim, output int t, output logic [1:0] who);
    t = -1; who = 2'b00;
    for (int i = 0; i < lim; i++) begin
      if (ifu_ack0 || lsu_ack0) begin
        t = cyc; who = {lsu_ack0, ifu_ack0}; return;
      end
      tick();
    end
  endtask

  logic         cs_h [0:31];
  logic [1:0]   dn_h [0:31];
  logic [1:0]   ak_h [0:31];
  sqi_io_mode_t md_h [0:31];
  logic [15:0]  rd_h [0:31];

  task automatic run_txn(input int len, input logic [1:0] drop);
    for (int k = 1; k <= len + 1; k++) begin
      tick();
      if (k == 1) begin
        if (drop[0]) ifu_req = 0;
        if (drop[1]) lsu_req = 0;
        #1;
      end
      cs_h[k] = cs0; md_h[k] = mode0; rd_h[k] = rdata0;
      dn_h[k] = {lsu_done0, ifu_done0}; ak_h[k] = {lsu_ack0, ifu_ack0};
    end
  endtask

  task automatic check_txn(input string tg, input logic [1:0] o, input int len);
    logic [1:0] acc;
    acc = 2'b00;
    for (int k = 1; k < len; k++) acc |= dn_h[k] | ak_h[k];
    chk({tg, "_quiet"}, acc, 2'b00);
    chk({tg, "_done"}, dn_h[len], o);
    chk({tg, "_cs_first"}, cs_h[1], 1'b0);
    chk({tg, "_cs_last"}, cs_h[len - 1], 1'b0);
    chk({tg, "_cs_rel"}, cs_h[len], 1'b1);
  endtask

  // Release reset with ifu_req already set; expect a full EQIO then the ack.
  task automatic init_then_ack(input string tg, output int t);
    int low;
    low = 0; t = -1;
    rst_n = 1;
    for (int i = 0; i < 40 && t < 0; i++) begin
      tick();
      if (ifu_ack0) t = cyc;
      else if (!cs0) low++;
    end
    chk({tg, "_low_cycles"}, low, 16);
    chk({tg, "_eqio"}, last_init, 8'h38);
    chk({tg, "_hi_bits"}, init_hi, 1'b0);
    chk({tg, "_ack"}, ifu_ack0, 1'b1);
  endtask

  int t0, t1;
  logic [1:0] who;
  logic [1:0] rr_exp [3];
  int len, bad;

  initial begin
    rr_exp = '{2'b01, 2'b10, 2'b01};
    #1 rst_n = 0;
    repeat (3) tick();
    chk("rst_cs", cs0, 1'b1);
    chk("rst_sck", sck0, 1'b0);
    chk("rst_mode", mode0, SQI_IO_MODE_IN);
    chk("rst_rdata", rdata0, 16'h0);
    ifu_req = 1; ifu_addr = 16'h1234;
    tick();
    chk("rst_no_ack", {ifu_ack0, ifu_ack1}, 2'b00);

    // IFU read 0x1234 -> 0xBEEF
    init_then_ack("init", t0);
    run_txn(25, 2'b01);
    check_txn("rd", 2'b01, 25);
    chk("rd_mode12", md_h[12], SQI_IO_MODE_OUT);
    chk("rd_mode13", md_h[13], SQI_IO_MODE_IN);
    chk("rd_data", rd_h[25], 16'hBEEF);
    chk("rd_nibs", {nibq[0], nibq[1], nibq[2], nibq[3], nibq[4], nibq[5]}, 24'h031234);

    // LSU write 0x00FF <- 0xA55A, issued before the controller is idle again
    lsu_wr = 1; lsu_addr = 16'h00FF; lsu_wdata = 16'hA55A; lsu_req = 1; #1;
    wait_ack(5, t1, who);
    chk("wr_owner", who, 2'b10);
    chk("wr_ack_gap", t1 - t0, 27);
    run_txn(21, 2'b10);
    check_txn("wr", 2'b10, 21);
    bad = 0;
    for (int k = 1; k <= 20; k++) if (md_h[k] != SQI_IO_MODE_OUT) bad++;
    chk("wr_mode_out", bad, 0);
    chk("wr_nibs", {nibq[0], nibq[1], nibq[2], nibq[3], nibq[4], nibq[5], nibq[6],
                    nibq[7], nibq[8], nibq[9]}, 40'h0200FFA55A);
    chk("wr_mem_ff", mem[16'h00FF], 8'hA5);
    chk("wr_mem_100", mem[16'h0100], 8'h5A);

    // Both held: round-robin IFU, LSU, IFU
    lsu_addr = 16'h0200; lsu_wdata = 16'h1357; ifu_addr = 16'h1234;
    ifu_req = 1; lsu_req = 1; #1;
    for (int j = 0; j < 3; j++) begin
      wait_ack(30, t1, who);
      chk("rr_ack", who, rr_exp[j]);
      len = (who == 2'b10) ? 21 : 25;
      run_txn(len, 2'b00);
      check_txn("rr", who, len);
      if (who == 2'b01) chk("rr_rdata", rd_h[25], 16'hBEEF);
    end
    ifu_req = 0; lsu_req = 0;
    chk("rr_mem_200", mem[16'h0200], 8'h13);

    // Reset in the middle of a read
    ifu_addr = 16'h0200; ifu_req = 1; tick(); #1;
    wait_ack(5, t1, who);
    chk("mid_owner", who, 2'b01);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) ifu_req = 0;
    end
    rst_n = 0; #1;
    chk("mid_cs", cs0, 1'b1);
    chk("mid_sck", sck0, 1'b0);
    chk("mid_mode", mode0, SQI_IO_MODE_IN);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (ifu_done0 || lsu_done0) bad++;
      tick();
    end
    chk("mid_no_done", bad, 0);
    chk("mid_rdata", rdata0, 16'h0);
    ifu_req = 1;
    init_then_ack("reinit", t0);
    run_txn(25, 2'b01);
    check_txn("rd2", 2'b01, 25);
    chk("rd2_data", rd_h[25], 16'h1357);

    // INIT_EN=0 instance: LSU read of 0xFFFF right after reset
    rst_n = 0; ifu_req = 0; lsu_req = 1; lsu_wr = 0; lsu_addr = 16'hFFFF; sio_in1 = 4'hC;
    tick();
    chk("ni_rst_ack", lsu_ack1, 1'b0);
    rst_n = 1;
    tick();
    chk("ni_ack", lsu_ack1, 1'b1);
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 1) lsu_req = 0;
      if (k == 24) chk("ni_done_early", lsu_done1, 1'b0);
      if (k == 25) begin
        chk("ni_done", {lsu_done1, ifu_done1}, 2'b10);
        chk("ni_rdata", rdata1, 16'hCCCC);
      end
    end
    chk("ni_nibs", {nibq1[0], nibq1[1], nibq1[2], nibq1[3], nibq1[4], nibq1[5]}, 24'h03FFFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/idli_sqi_ctrl_m.md
Name: idli_sqi_ctrl_m

Overview:
- Sequences the external SQI serial SRAM behind the core's memory pins: drives SCK, CS, SIO and the SIO direction mode.
- Arbitrates between two requesters, instruction fetch (IFU) and load/store (LSU), one 16-bit word per transaction.
- After reset, switches the SRAM into quad mode with a single-bit EQIO command before accepting any request.

Parameters:
- INIT_EN, 1, when 1 issue EQIO (0x38) after reset; when 0 go straight to IDLE.

Ports:
- i_sqi_gck  in  1  core clock
- i_sqi_rst_n  in  1  reset; asynchronous, active-low
- i_sqi_ifu_req  in  1  fetch request, held until ack
- i_sqi_ifu_addr  in  16  fetch byte address
- o_sqi_ifu_ack  out  1  fetch granted this cycle; inputs captured
- o_sqi_ifu_done  out  1  one-cycle pulse, fetch data valid on o_sqi_rdata
- i_sqi_lsu_req  in  1  load/store request, held until ack
- i_sqi_lsu_wr  in  1  1 = write, 0 = read
- i_sqi_lsu_addr  in  16  load/store byte address
- i_sqi_lsu_wdata  in  16  write data
- o_sqi_lsu_ack  out  1  load/store granted this cycle
- o_sqi_lsu_done  out  1  one-cycle pulse, transaction complete (rdata valid if read)
- o_sqi_rdata  out  16  last read word, held until next read completes
- o_sqi_sck  out  1  memory serial clock
- o_sqi_cs  out  1  memory chip select, active-low
- o_sqi_io_mode  out  sqi_io_mode_t  SIO direction (OUT = drive pins)
- i_sqi_sio  in  4  memory SIO inputs
- o_sqi_sio  out  4  memory SIO outputs

Behaviour:
- Reset (async, immediate even mid-transaction): cs=1, sck=0, io_mode=IN, o_sio=0, acks/dones=0, rdata=0, rr pointer = LSU-last. State: INIT if INIT_EN, else IDLE.
- Bit/nibble timing: each beat = 2 gck cycles. Phase 0: sck=0, o_sio updated. Phase 1: sck=1; the memory samples on the rising SCK edge. Read data is captured from i_sio on the gck edge that ends phase 1.
- Byte and nibble order: MSB first. Word = byte at addr in [15:8], byte at addr+1 in [7:0].
- INIT: cs=0, io_mode=OUT, 8 beats, bit i of 0x38 on o_sio[0] (MSB first), others 0. Total 16 cycles, then DESEL. No acks during INIT.
- IDLE: cs=1, sck=0, io_mode=IN.
  - Arbitration when both request: round-robin, grant the requester not granted last. A single requester is always granted.
  - Grant is combinational in the IDLE cycle; ack is high for exactly that cycle. Owner, wr, addr and wdata are registered on that edge (IFU wr=0).
  - Next cycle enters CMD.
- CMD: 2 nibbles of 0x03 (read) or 0x02 (write), io_mode=OUT, cs=0.
- ADDR: 4 nibbles of addr[15:0].
- DUMMY (reads only): 2 beats. io_mode=IN from the first cycle of DUMMY; o_sio=0.
- DATA:
  - Write: 4 nibbles of wdata, io_mode=OUT.
  - Read: io_mode=IN, 4 nibbles shifted into a shift register.
- DESEL: 2 cycles, cs=1, sck=0, io_mode=IN.
  - First cycle: owner's done pulse; o_sqi_rdata updated on that cycle for reads.
  - After INIT, DESEL produces no done.
  - Then IDLE.
- Latency from ack cycle T:
  - Read: cs low T+1..T+24, done T+25, next ack earliest T+27.
  - Write: cs low T+1..T+20, done T+21, next ack earliest T+23.
- Requests arriving mid-transaction wait; req dropped before ack is legal and is simply not granted. ack and done never coincide for the same requester.
- A beat counter (3 bits) plus phase bit drives all state transitions; no state lasts longer than 8 beats.

Decomposition:
- idli_pkg gets:
  - sqi_ctrl_state_t {INIT, IDLE, CMD, ADDR, DUMMY, DATA, DESEL}
  - sqi_owner_t {SQI_OWNER_IFU, SQI_OWNER_LSU}
  - constants SQI_CMD_READ=8'h03, SQI_CMD_WRITE=8'h02, SQI_CMD_EQIO=8'h38
  - reuses existing sqi_io_mode_t
- One sub-module: idli_sqi_arb_m, a 2-way round-robin arbiter (req[1:0], advance -> grant one-hot, last-owner register).

Test Plan:
- Reset then release, INIT_EN=1 -> cs=1/sck=0/io_mode=IN during reset; then 16 cycles of cs=0 with o_sio[0] = 0,0,1,1,1,0,0,0 on sck rising; no ack before IDLE.
- IFU read addr 0x1234, SRAM model returns 0xBEEF -> o_sio nibbles 0,3,1,2,3,4; io_mode IN from T+13; ifu_done at T+25 with rdata=0xBEEF.
- LSU write addr 0x00FF data 0xA55A -> nibbles 0,2,0,0,F,F,A,5,5,A; io_mode OUT throughout cs low; lsu_done at T+21; model memory holds 0xA5 at 0x00FF and 0x5A at 0x0100.
- IFU and LSU requesting together from reset, both held -> acks alternate IFU, LSU, IFU; each done matches its owner.
- Assert rst_n low at T+10 of a read -> cs=1, sck=0, io_mode=IN immediately, no done pulse; after release, INIT repeats and a new read completes correctly.
- INIT_EN=0, LSU read of 0xFFFF -> ack on first IDLE cycle after reset; address nibbles F,F,F,F; done at T+25.
